// File: rtl/pwm_btn_pkg.sv
// Shared types and default constants for the PWM button conditioner.
package pwm_btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2,
        LOCKED = 2'd3
    } btn_state_e;

    localparam int CNT_W_DEF         = 28;
    localparam int DEB_CYCLES_DEF    = 2;
    localparam int REPEAT_DELAY_DEF  = 8;
    localparam int REPEAT_PERIOD_DEF = 4;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, stable-count debouncer and the
// debounced level. Also tracks whether the button has been seen released
// since reset, so a button held through reset cannot produce a press.
module btn_debounce_ch
    import pwm_btn_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic level_nxt,
    output logic press
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [1:0]       vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             armed_q, armed_d;

    // Next-state: sync shift, debounce count, level flip, release-seen arming
    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        // vld_q[1] marks that s2 holds a real post-reset sample
        vld_d   = {vld_q[0], 1'b1};
        level_d = level_q;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == DEB_LAST) level_d = s2_q;
            else                   cnt_d   = cnt_q + CNT_W'(1);
        end
        armed_d = armed_q | (vld_q[1] & ~s2_q);
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            vld_q   <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            armed_q <= armed_d;
        end
    end

    assign level     = level_q;
    assign level_nxt = level_d;
    assign press     = armed_q & ~level_q & level_d;

endmodule

// File: rtl/pwm_button_conditioner.sv
// Button front-end for the PWM duty controller: two debounced channels,
// per-channel press FSMs with mutual exclusion, registered step pulses.
// Optional auto-repeat while held: define BTN_AUTOREPEAT_EN.
module pwm_button_conditioner
    import pwm_btn_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
`ifdef BTN_AUTOREPEAT_EN
   ,parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_inc_raw,
    input  logic btn_dec_raw,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_level,
    output logic dec_level
);

    // Channel index 0 = increase, 1 = decrease
    logic [1:0] raw, lvl_q, lvl_d, press;
    logic [1:0] pulse_q, pulse_d;
    btn_state_e state_q [2];
    btn_state_e state_d [2];

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    logic [CNT_W-1:0] rcnt_q [2];
    logic [CNT_W-1:0] rcnt_d [2];
`endif

    assign raw = {btn_dec_raw, btn_inc_raw};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        btn_debounce_ch #(
            .CNT_W      (CNT_W),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw       (raw[g]),
            .level     (lvl_q[g]),
            .level_nxt (lvl_d[g]),
            .press     (press[g])
        );
    end

    // Press FSMs; decisions use next-cycle levels so the pulse lands with the level edge
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            state_d[c] = state_q[c];
            pulse_d[c] = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_d[c]  = rcnt_q[c];
`endif
            if (!ena || !lvl_d[c]) begin
                state_d[c] = IDLE;
`ifdef BTN_AUTOREPEAT_EN
                rcnt_d[c]  = '0;
`endif
            end else begin
                case (state_q[c])
                    IDLE: begin
                        if (press[c]) begin
                            // other button held or rising at the same edge: ignore this press
                            if (lvl_d[1-c]) begin
                                state_d[c] = LOCKED;
                            end else begin
                                state_d[c] = HELD;
                                pulse_d[c] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                                rcnt_d[c]  = '0;
`endif
                            end
                        end
                    end
`ifdef BTN_AUTOREPEAT_EN
                    HELD: begin
                        if (lvl_d[1-c]) begin
                            state_d[c] = LOCKED;
                        end else if (rcnt_q[c] == DELAY_LAST) begin
                            pulse_d[c] = 1'b1;
                            rcnt_d[c]  = '0;
                            state_d[c] = REPEAT;
                        end else begin
                            rcnt_d[c]  = rcnt_q[c] + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (lvl_d[1-c]) begin
                            state_d[c] = LOCKED;
                        end else if (rcnt_q[c] == PERIOD_LAST) begin
                            pulse_d[c] = 1'b1;
                            rcnt_d[c]  = '0;
                        end else begin
                            rcnt_d[c]  = rcnt_q[c] + CNT_W'(1);
                        end
                    end
`endif
                    // HELD without repeat and LOCKED both just wait for release
                    default: ;
                endcase
            end
        end
    end

    // FSM state and output pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '{default: IDLE};
            pulse_q <= '0;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_q  <= '{default: '0};
`endif
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_q  <= rcnt_d;
`endif
        end
    end

    assign inc_pulse = pulse_q[0];
    assign dec_pulse = pulse_q[1];
    assign inc_level = lvl_q[0];
    assign dec_level = lvl_q[1];

endmodule
